// File: rtl/permutation_round_ctrl.sv
// Ascon permutation sequencer: holds the 320-bit state, counts rounds for p^a / p^b
// and feeds the state and round index back into the round datapath.
module permutation_round_ctrl #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [4:0][63:0] state_init_i,
    input  logic [4:0][63:0] state_xor_end_i,
    output logic [4:0][63:0] state_loop_o,
    output logic [3:0]       round_o,
    output logic             last_round_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Round indices count up to 11 so that constant addition sees the same
    // values for the tail of p^a and for the whole of p^b.
    localparam logic [3:0] ROUND_LAST    = 4'd11;
    localparam logic [3:0] ROUND_START_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] ROUND_START_B = 4'(12 - NB_ROUNDS_B);

    fsm_t             fsm_r;
    logic [4:0][63:0] state_r;
    logic [3:0]       round_r;
    logic             busy_r;
    logic             last_round_r;
    logic             done_r;
    logic [3:0]       start_round_s;

    // First round index of the permutation requested by mode_i.
    always_comb begin
        start_round_s = ROUND_START_A;
        if (mode_i) begin
            start_round_s = ROUND_START_B;
        end else begin
            start_round_s = ROUND_START_A;
        end
    end

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_r        <= ST_IDLE;
            state_r      <= '0;
            round_r      <= 4'd0;
            busy_r       <= 1'b0;
            last_round_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        fsm_r        <= ST_RUN;
                        state_r      <= state_init_i;
                        round_r      <= start_round_s;
                        busy_r       <= 1'b1;
                        last_round_r <= (start_round_s == ROUND_LAST);
                    end else begin
                        fsm_r        <= ST_IDLE;
                        busy_r       <= 1'b0;
                        last_round_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r <= state_xor_end_i;
                    if (round_r == ROUND_LAST) begin
                        // round index stays at 11 so it never wraps
                        fsm_r        <= ST_DONE;
                        busy_r       <= 1'b0;
                        last_round_r <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        round_r      <= round_r + 4'd1;
                        last_round_r <= ((round_r + 4'd1) == ROUND_LAST);
                        done_r       <= 1'b0;
                    end
                end
                default: begin
                    fsm_r        <= ST_IDLE;
                    busy_r       <= 1'b0;
                    last_round_r <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign state_loop_o = state_r;
    assign round_o      = round_r;
    assign busy_o       = busy_r;
    assign last_round_o = last_round_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Self-checking bench for permutation_round_ctrl: directed scenarios plus random
// launches, checked every cycle against a queue-based reference model.
module tb_permutation_round_ctrl;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             use_chain = 1'b0;
    logic [4:0][63:0] init = '0;
    logic [4:0][63:0] xor_end;
    logic [4:0][63:0] loop_state;
    logic [3:0]       round;
    logic             last_round;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [3:0]       m_q[$];
    logic [4:0][63:0] m_state = '0;
    logic [3:0]       m_round = 4'd0;
    logic             m_done  = 1'b0;

    permutation_round_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start),
        .mode_i         (mode),
        .state_init_i   (init),
        .state_xor_end_i(xor_end),
        .state_loop_o   (loop_state),
        .round_o        (round),
        .last_round_o   (last_round),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        c  = {4'hf - r, r};
        x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [4:0][63:0] round_fn(input logic [4:0][63:0] s, input logic [3:0] r,
                                                   input logic chain);
        logic [4:0][63:0] o;
        if (chain) begin
            o = ascon_round(s, r);
        end else begin
            o = s;
            o[0] = s[0] + 64'd1;
        end
        return o;
    endfunction

    assign xor_end = round_fn(loop_state, round, use_chain);

    task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_edge();
        logic [3:0] r;
        int n;
        if (m_q.size() != 0) begin
            m_state = round_fn(m_state, m_q[0], use_chain);
            r = m_q.pop_front();
            if (m_q.size() == 0) begin
                m_done  = 1'b1;
                m_round = r;
            end else begin
                m_round = m_q[0];
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                n = mode ? 6 : 12;
                m_state = init;
                for (int i = 12 - n; i < 12; i++) m_q.push_back(4'(i));
                m_round = m_q[0];
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = '0;
        m_round = 4'd0;
        m_done  = 1'b0;
    endtask

    task automatic compare_all();
        logic exp_busy;
        exp_busy = (m_q.size() != 0);
        check_eq("state", loop_state, m_state);
        check_eq("round", {316'd0, round}, {316'd0, m_round});
        check_eq("busy", {319'd0, busy}, {319'd0, exp_busy});
        check_eq("last_round", {319'd0, last_round}, {319'd0, exp_busy && (m_round == 4'd11)});
        check_eq("done", {319'd0, done}, {319'd0, m_done});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_state(output logic [4:0][63:0] s);
        for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    endtask

    initial begin
        logic [4:0][63:0] init2;

        // reset state
        #1;
        compare_all();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        compare_all();

        // p^a from zero with the increment stub
        start = 1'b1; mode = 1'b0; init = '0;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check_eq("t1_done", {319'd0, done}, {319'd0, 1'b1});
        check_eq("t1_word0", {256'd0, loop_state[0]}, {256'd0, 64'd12});
        step();

        // p^b with word0 = 0x100, other words random
        rand_state(init2);
        init2[0] = 64'h100;
        start = 1'b1; mode = 1'b1; init = init2;
        step();
        start = 1'b0; init = '0;
        for (int i = 0; i < 6; i++) step();
        check_eq("t2_word0", {256'd0, loop_state[0]}, {256'd0, 64'h106});
        check_eq("t2_word4", {256'd0, loop_state[4]}, {256'd0, init2[4]});
        step();

        // start held high, mode toggled mid-run, back-to-back relaunch
        start = 1'b1; mode = 1'b0; init = '0;
        step();
        for (int i = 0; i < 12; i++) begin
            mode = ~mode;
            rand_state(init);
            step();
        end
        check_eq("t3_done", {319'd0, done}, {319'd0, 1'b1});
        mode = 1'b1; init = '0; init[0] = 64'd5;
        step();
        check_eq("t3_relaunch_round", {316'd0, round}, {316'd0, 4'd6});
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("t3_word0", {256'd0, loop_state[0]}, {256'd0, 64'd11});
        step();

        // asynchronous reset while round_o = 4
        start = 1'b1; mode = 1'b0; rand_state(init);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("t4_round_before", {316'd0, round}, {316'd0, 4'd4});
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;
        compare_all();
        step();
        compare_all();

        // fresh run through a real Ascon round chain
        use_chain = 1'b1;
        start = 1'b1; mode = 1'b0; rand_state(init);
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check_eq("t5_done", {319'd0, done}, {319'd0, 1'b1});
        step();

        // random launches, alternating between stub and chain rounds
        for (int phase = 0; phase < 2; phase++) begin
            use_chain = phase[0];
            for (int i = 0; i < 300; i++) begin
                start = ($urandom_range(0, 3) == 0);
                mode  = 1'($urandom_range(0, 1));
                rand_state(init);
                step();
            end
            start = 1'b0;
            for (int i = 0; i < 14; i++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
